pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, hold and flush control. It sits between any two pipeline stages (IF/ID, ID/EX, ...) and carries a PC and an instruction word. `in_ready` is registered, so no combinational path runs from `out_ready` to `in_ready`. A flushed or empty stage presents a configurable NOP to the next stage.

---
 rtl/pipe_stage_buf.sv | 136 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// The head register drives the outputs; the skid register absorbs one entry while the downstream stalls.
module pipe_stage_buf #(
    parameter int unsigned        PC_W      = 16,
    parameter int unsigned        INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               hold,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         level
);

    localparam logic [1:0] LV_EMPTY = 2'd0;
    localparam logic [1:0] LV_BUSY  = 2'd1;
    localparam logic [1:0] LV_FULL  = 2'd2;

    logic               r_out_valid;
    logic [PC_W-1:0]    r_out_pc;
    logic [INSTR_W-1:0] r_out_instr;
    logic               r_skid_valid;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [1:0]         r_level;
    logic               r_in_ready;

    logic       w_accept;
    logic       w_drain;
    logic [1:0] w_level_nxt;
    logic       w_head_load_in;
    logic       w_head_load_skid;
    logic       w_head_clear;
    logic       w_skid_load;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready & ~hold;

    always_comb begin
        w_level_nxt      = r_level;
        w_head_load_in   = 1'b0;
        w_head_load_skid = 1'b0;
        w_head_clear     = 1'b0;
        w_skid_load      = 1'b0;
        case (r_level)
            LV_EMPTY: begin
                if (w_accept) begin
                    w_head_load_in = 1'b1;
                    w_level_nxt    = LV_BUSY;
                end
            end
            LV_BUSY: begin
                if (w_accept && w_drain) begin
                    w_head_load_in = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_level_nxt = LV_FULL;
                end else if (w_drain) begin
                    w_head_clear = 1'b1;
                    w_level_nxt  = LV_EMPTY;
                end
            end
            LV_FULL: begin
                if (w_drain && r_skid_valid) begin
                    w_head_load_skid = 1'b1;
                    w_level_nxt      = LV_BUSY;
                end
            end
            default: begin
                w_head_clear = 1'b1;
                w_level_nxt  = LV_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_instr  <= NOP_INSTR;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_level      <= LV_EMPTY;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            // out_pc deliberately keeps its last value across a flush
            r_out_valid  <= 1'b0;
            r_out_instr  <= NOP_INSTR;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_level      <= LV_EMPTY;
            r_in_ready   <= 1'b1;
        end else begin
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt != LV_FULL);
            if (w_head_load_in) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= in_pc;
                r_out_instr <= in_instr;
            end else if (w_head_load_skid) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= r_skid_pc;
                r_out_instr <= r_skid_instr;
            end else if (w_head_clear) begin
                r_out_valid <= 1'b0;
                r_out_instr <= NOP_INSTR;
            end
            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= in_pc;
                r_skid_instr <= in_instr;
            end else if (w_head_load_skid) begin
                r_skid_valid <= 1'b0;
                r_skid_pc    <= '0;
                r_skid_instr <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_instr = r_out_instr;
    assign level     = r_level;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table and sequences on a 16-bit instance,
// randomized queue-model checking on a 32-bit instance with a non-zero NOP.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_in_valid, a_in_ready, a_hold, a_flush, a_out_valid, a_out_ready;
    logic [15:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
    logic [1:0]  a_level;

    logic        b_in_valid, b_in_ready, b_hold, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
    logic [1:0]  b_level;

    pipe_stage_buf u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
        .hold(a_hold), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
        .level(a_level)
    );

    pipe_stage_buf #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0013)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
        .hold(b_hold), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
        .level(b_level)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [15:0] epc,
                         input logic [15:0] eins, input logic [1:0] elv, input logic erdy);
        chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(ev));
        chk({tag, ".out_pc"},    32'(a_out_pc),    32'(epc));
        chk({tag, ".out_instr"}, 32'(a_out_instr), 32'(eins));
        chk({tag, ".level"},     32'(a_level),     32'(elv));
        chk({tag, ".in_ready"},  32'(a_in_ready),  32'(erdy));
    endtask

    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [15:0] ins;
        logic        hold;
        logic        flush;
        logic        ordy;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eins;
        logic [1:0]  elv;
        logic        erdy;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;

    initial begin
        // v, pc, ins, hold, flush, ordy  ->  valid, pc, instr, level, in_ready
        tbl.push_back('{1'b1, 16'h0010, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h00A1, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0012, 16'h00B2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h00A1, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 16'h0014, 16'h00DD, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h00A1, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h00A1, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h00B2, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 16'h0020, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0011, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0022, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0011, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 16'h0024, 16'h00C3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 16'h0030, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0033, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 16'h0040, 16'hF044, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hF044, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0042, 16'hE045, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 16'hE045, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0044, 16'h0046, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'hE045, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0044, 16'h0046, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0046, 16'h0047, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0044, 16'h0046, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0046, 16'h0047, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0046, 16'h0000, 2'd0, 1'b1});

        reset = 1'b0;
        a_in_valid = 1'b0; a_in_pc = '0; a_in_instr = '0; a_hold = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_pc = '0; b_in_instr = '0; b_hold = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;

        #12;
        chk_a("reset", 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1);
        chk("reset_b.out_instr", b_out_instr, 32'h0000_0013);
        chk("reset_b.level", 32'(b_level), 32'd0);

        // Streaming straight out of reset: PCs 0,2,4,... one per cycle
        a_in_valid = 1'b1; a_in_pc = 16'h0000; a_in_instr = 16'h1000; a_out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("stream_pre.out_valid", 32'(a_out_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk_a("stream", 1'b1, 16'(2 * k), 16'(16'h1000 + k), 2'd1, 1'b1);
            a_in_pc    = 16'(2 * (k + 1));
            a_in_instr = 16'(16'h1000 + k + 1);
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk_a("stream_end", 1'b0, 16'h000E, 16'h0000, 2'd0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            a_in_valid = tbl[i].v; a_in_pc = tbl[i].pc; a_in_instr = tbl[i].ins;
            a_hold = tbl[i].hold; a_flush = tbl[i].flush; a_out_ready = tbl[i].ordy;
            @(posedge clk); #1;
            chk_a($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eins, tbl[i].elv, tbl[i].erdy);
        end
        a_hold = 1'b0; a_flush = 1'b0;

        // Asynchronous reset between edges while full
        a_in_valid = 1'b1; a_in_pc = 16'h0050; a_in_instr = 16'h0055; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_pc = 16'h0052; a_in_instr = 16'h0056;
        @(posedge clk); #1;
        chk("async_pre.level", 32'(a_level), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        chk_a("async", 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_a("async_post", 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1);

        // Randomized run on the 32-bit instance against a capacity-2 queue model
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_q.delete();
        m_pc = '0;
        for (int c = 0; c < 10000; c++) begin
            logic acc, drn;
            ent_t e;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_pc     = $urandom;
            b_in_instr  = $urandom;
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_hold      = ($urandom_range(0, 4) == 0);
            b_flush     = ($urandom_range(0, 49) == 0);
            if (b_flush) begin
                m_q.delete();
            end else begin
                acc = b_in_valid && (m_q.size() < 2);
                drn = (m_q.size() > 0) && b_out_ready && !b_hold;
                if (drn) void'(m_q.pop_front());
                if (acc) begin
                    e.pc = b_in_pc;
                    e.instr = b_in_instr;
                    m_q.push_back(e);
                end
            end
            if (m_q.size() > 0) m_pc = m_q[0].pc;
            @(posedge clk); #1;
            chk("rnd.out_valid", 32'(b_out_valid), 32'(m_q.size() > 0));
            chk("rnd.out_pc", b_out_pc, m_pc);
            chk("rnd.out_instr", b_out_instr, (m_q.size() > 0) ? m_q[0].instr : 32'h0000_0013);
            chk("rnd.level", 32'(b_level), 32'(m_q.size()));
            chk("rnd.in_ready", 32'(b_in_ready), 32'(m_q.size() != 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
